// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity, then STOP_BITS stop bits. valid/ready handshake, done pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, ready=1, waiting for send
// S_START  | start bit (tx=0)
// S_DATA   | data bits shifted out LSB first
// S_PARITY | parity bit (only when parity_mode is 01 or 10)
// S_STOP   | stop bit(s); ready/done raised on the final cycle

module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        parity_mode,
    input  logic              send,
    output logic              ready,
    output logic              tx,
    output logic              done
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
            $error("uart_tx_cfg: DATA_W must be in 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_en;
    logic              par_bit;

    logic baud_end;
    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            done <= 1'b0;
            // ready is high in IDLE and on the last stop cycle, so this also chains frames
            if (send && ready) begin
                shreg    <= data;
                par_en   <= ^parity_mode;
                par_bit  <= (^data) ^ parity_mode[1];
                tx       <= 1'b0;
                ready    <= 1'b0;
                baud_cnt <= '0;
                bit_idx  <= '0;
                state    <= S_START;
            end else begin
                case (state)
                    S_IDLE: begin
                        tx       <= 1'b1;
                        baud_cnt <= '0;
                    end
                    S_START: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            tx       <= shreg[0];
                            shreg    <= shreg >> 1;
                            state    <= S_DATA;
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            if (bit_idx == DATA_LAST) begin
                                bit_idx <= '0;
                                if (par_en) begin
                                    tx    <= par_bit;
                                    state <= S_PARITY;
                                end else begin
                                    tx    <= 1'b1;
                                    state <= S_STOP;
                                end
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                                tx      <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            tx       <= 1'b1;
                            state    <= S_STOP;
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            if (bit_idx == STOP_LAST) begin
                                bit_idx <= '0;
                                state   <= S_IDLE;
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                            // registered outputs: raise one cycle early so they land on the final cycle
                            if (bit_idx == STOP_LAST && baud_cnt == BAUD_PRE) begin
                                done  <= 1'b1;
                                ready <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        tx    <= 1'b1;
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: two instances (8N1-style and 7-bit/2-stop),
// every frame cycle checked against a hand-built expected bit sequence.
module tb_uart_tx_cfg;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] data_a = '0;
    logic [1:0] mode_a = '0;
    logic       send_a = 1'b0;
    logic       ready_a, tx_a, done_a;

    logic [6:0] data_b = '0;
    logic [1:0] mode_b = '0;
    logic       send_b = 1'b0;
    logic       ready_b, tx_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(1)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .data       (data_a),
        .parity_mode(mode_a),
        .send       (send_a),
        .ready      (ready_a),
        .tx         (tx_a),
        .done       (done_a)
    );

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(7), .STOP_BITS(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .data       (data_b),
        .parity_mode(mode_b),
        .send       (send_b),
        .ready      (ready_b),
        .tx         (tx_b),
        .done       (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic [8:0] d, input logic [1:0] m, input logic s);
        if (sel) begin
            data_b = d[6:0];
            mode_b = m;
            send_b = s;
        end else begin
            data_a = d[7:0];
            mode_a = m;
            send_a = s;
        end
    endtask

    task automatic set_send(input bit sel, input logic s);
        if (sel) send_b = s;
        else     send_a = s;
    endtask

    task automatic idle_chk(input bit sel, input int ncyc, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            chk($sformatf("%s idle tx %0d", tag, i),    sel ? tx_b    : tx_a,    1'b1);
            chk($sformatf("%s idle ready %0d", tag, i), sel ? ready_b : ready_a, 1'b1);
            chk($sformatf("%s idle done %0d", tag, i),  sel ? done_b  : done_a,  1'b0);
            step();
        end
    endtask

    // Called one cycle before the accept edge; returns on the final stop cycle.
    // Mid-frame it changes data/mode to nd/nm and pulses send, none of which may affect this frame.
    task automatic frame(input bit sel, input string tag,
                         input logic [8:0] d, input logic [1:0] m,
                         input bit par_on, input logic par_val,
                         input int dw, input int sb, input int exp_len,
                         input bit hold, input logic [8:0] nd, input logic [1:0] nm);
        logic bits [0:15];
        int   nb;
        int   len;
        bits[0] = 1'b0;
        for (int i = 0; i < dw; i++) bits[1+i] = d[i];
        nb = 1 + dw;
        if (par_on) begin
            bits[nb] = par_val;
            nb = nb + 1;
        end
        for (int i = 0; i < sb; i++) begin
            bits[nb] = 1'b1;
            nb = nb + 1;
        end
        len = nb * CPB;
        chk({tag, " len"}, len, exp_len);
        drive(sel, d, m, 1'b1);
        step();
        for (int n = 1; n <= len; n++) begin
            chk($sformatf("%s tx c%0d", tag, n),    sel ? tx_b    : tx_a,    bits[(n-1)/CPB]);
            chk($sformatf("%s ready c%0d", tag, n), sel ? ready_b : ready_a, n == len);
            chk($sformatf("%s done c%0d", tag, n),  sel ? done_b  : done_a,  n == len);
            if (n == 2) drive(sel, nd, nm, 1'b0);
            set_send(sel, (n == 10) || (n == 20) || (hold && n == len));
            if (n < len) step();
        end
    endtask

    initial begin
        // reset
        step(); step(); step();
        rst = 1'b0;
        chk("rst tx_a", tx_a, 1'b1);
        chk("rst ready_a", ready_a, 1'b1);
        chk("rst done_a", done_a, 1'b0);
        chk("rst tx_b", tx_b, 1'b1);
        chk("rst ready_b", ready_b, 1'b1);
        chk("rst done_b", done_b, 1'b0);
        step();

        // no parity, 0x55
        frame(0, "a55n", 9'h055, 2'b00, 0, 1'b0, 8, 1, 40, 0, 9'h0FF, 2'b01);
        step(); idle_chk(0, 3, "a55n");

        // 0x55 even -> 0, odd -> 1
        frame(0, "a55e", 9'h055, 2'b01, 1, 1'b0, 8, 1, 44, 0, 9'h001, 2'b10);
        step(); idle_chk(0, 2, "a55e");
        frame(0, "a55o", 9'h055, 2'b10, 1, 1'b1, 8, 1, 44, 0, 9'h000, 2'b00);
        step(); idle_chk(0, 2, "a55o");

        // 0x00 odd -> 1; 0x80 even -> 1; mode 11 is no parity
        frame(0, "a00o", 9'h000, 2'b10, 1, 1'b1, 8, 1, 44, 0, 9'h0FF, 2'b01);
        step(); idle_chk(0, 2, "a00o");
        frame(0, "a80e", 9'h080, 2'b01, 1, 1'b1, 8, 1, 44, 0, 9'h07F, 2'b10);
        step(); idle_chk(0, 2, "a80e");
        frame(0, "ac3x", 9'h0C3, 2'b11, 0, 1'b0, 8, 1, 40, 0, 9'h000, 2'b01);
        step(); idle_chk(0, 2, "ac3x");

        // back-to-back: send held through the end of frame 1, zero gap
        frame(0, "aA5", 9'h0A5, 2'b00, 0, 1'b0, 8, 1, 40, 1, 9'h03C, 2'b00);
        frame(0, "a3C", 9'h03C, 2'b00, 0, 1'b0, 8, 1, 40, 0, 9'h011, 2'b10);
        step(); idle_chk(0, 12, "a3C");

        // async reset in the middle of data bit 3 (frame cycles 17..20)
        drive(0, 9'h000, 2'b00, 1'b1);
        step();
        set_send(0, 1'b0);
        for (int i = 1; i < 18; i++) step();
        chk("mid bit3 tx", tx_a, 1'b0);
        chk("mid ready", ready_a, 1'b0);
        rst = 1'b1;
        #1;
        chk("async rst tx", tx_a, 1'b1);
        chk("async rst ready", ready_a, 1'b1);
        chk("async rst done", done_a, 1'b0);
        step(); step();
        rst = 1'b0;
        idle_chk(0, 3, "post rst");
        frame(0, "a55r", 9'h055, 2'b01, 1, 1'b0, 8, 1, 44, 0, 9'h0AA, 2'b10);
        step(); idle_chk(0, 2, "a55r");

        // 7 data bits, 2 stop bits
        frame(1, "b41e", 9'h041, 2'b01, 1, 1'b0, 7, 2, 44, 0, 9'h07F, 2'b10);
        step(); idle_chk(1, 2, "b41e");
        frame(1, "b41n", 9'h041, 2'b00, 0, 1'b0, 7, 2, 40, 0, 9'h000, 2'b01);
        step(); idle_chk(1, 2, "b41n");
        frame(1, "b2Ao", 9'h02A, 2'b10, 1, 1'b0, 7, 2, 44, 0, 9'h055, 2'b00);
        step(); idle_chk(1, 2, "b2Ao");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
